// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised single-clock FIFO, any depth, FWFT or registered read
// Level-tracked occupancy with threshold flags, sticky error flags and synchronous flush.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int LW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  flush;
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap at DEPTH-1 explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign flush        = rst || clr;
  assign full         = (level_q == LVL_FULL);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rd_acc = rd_en && !empty;
  // A read at full frees a slot in the same edge, so the write still lands.
  assign wr_acc = wr_en && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      level_q <= level_q + LW'(1);
      else if (rd_acc && !wr_acc) level_q <= level_q - LW'(1);
      if (wr_en && !wr_acc) overflow_q  <= 1'b1;
      if (rd_en && empty)   underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (flush)       rd_q <= '0;
        else if (rd_acc) rd_q <= mem[rd_ptr];
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - scoreboard bench for fifo_flex, both read modes side by side
// A queue model predicts occupancy, flags and read order; a monitor checks popped words.
module tb_fifo_flex;
  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AF    = 10;
  localparam int AE    = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [LW-1:0] level0, level1;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_reg (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .level(level0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(AF), .AEMPTY_TH(AE)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .level(level1), .overflow(ovf1), .underflow(unf1)
  );

  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];
  logic [DW-1:0] exp_rd0 = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            pend0 = 1'b0;
  int            n_pass = 0;
  int            n_total = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic check_dut(input string tag, input logic [LW-1:0] lvl, input logic f,
                           input logic e, input logic a_f, input logic a_e,
                           input logic ov, input logic un);
    int sz;
    sz = mq.size();
    chk({tag, " level"}, int'(lvl), sz);
    chk({tag, " full"}, int'(f), int'(sz == DEPTH));
    chk({tag, " empty"}, int'(e), int'(sz == 0));
    chk({tag, " almost_full"}, int'(a_f), int'(sz >= AF));
    chk({tag, " almost_empty"}, int'(a_e), int'(sz <= AE));
    chk({tag, " overflow"}, int'(ov), int'(m_ovf));
    chk({tag, " underflow"}, int'(un), int'(m_unf));
  endtask

  task automatic check_state();
    check_dut("reg", level0, full0, empty0, af0, ae0, ovf0, unf0);
    check_dut("fwft", level1, full1, empty1, af1, ae1, ovf1, unf1);
    chk("reg rd_data hold", int'(rd_data0), int'(exp_rd0));
    chk("fwft rd_data shown", int'(rd_data1), (mq.size() > 0) ? int'(mq[0]) : 0);
  endtask

  // Check the state left by previous edges, then drive this cycle and advance the model.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
    bit rd_ok, wr_ok;
    logic [DW-1:0] popped;
    @(posedge clk);
    #1;
    check_state();
    wr_en = w; wr_data = d; rd_en = r; clr = c; rst = rs;
    if (rs || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      exp_rd0 = '0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < DEPTH) || r);
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && mq.size() == 0) m_unf = 1'b1;
      if (rd_ok) begin
        popped = mq.pop_front();
        sb0.push_back(popped);
        sb1.push_back(popped);
        exp_rd0 = popped;
      end
      if (wr_ok) mq.push_back(d);
    end
  endtask

  task automatic wr(input logic [DW-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();                       step(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle();                     step(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
  task automatic flush();                    step(1'b0, '0, 1'b0, 1'b1, 1'b0); endtask

  initial begin
    forever begin
      @(negedge clk);
      if (pend0) begin
        if (sb0.size() == 0) chk("reg unexpected pop", 1, 0);
        else chk("reg read order", int'(rd_data0), int'(sb0.pop_front()));
      end
      pend0 = rd_en && !empty0 && !rst && !clr;
      if (rd_en && !empty1 && !rst && !clr) begin
        if (sb1.size() == 0) chk("fwft unexpected pop", 1, 0);
        else chk("fwft read order", int'(rd_data1), int'(sb1.pop_front()));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();

    for (int k = 1; k <= 12; k++) wr(DW'(k));
    repeat (6) rd();
    for (int k = 13; k <= 18; k++) wr(DW'(k));
    repeat (12) rd();

    for (int k = 0; k < DEPTH; k++) wr(DW'($urandom));
    repeat (DEPTH) rd();

    for (int k = 0; k < DEPTH; k++) wr(DW'(8'h20 + k));
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    idle();
    repeat (DEPTH) rd();

    for (int k = 0; k < DEPTH; k++) wr(DW'(8'h40 + k));
    wr(8'h55);
    repeat (2) idle();
    repeat (DEPTH) rd();
    rd();
    repeat (2) idle();
    flush();
    idle();

    wr(8'h3C);
    repeat (2) idle();
    rd();
    idle();

    flush();
    for (int k = 0; k < 7; k++) wr(DW'(8'h60 + k));
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    idle();
    for (int k = 0; k < 7; k++) wr(DW'(8'h70 + k));
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 900; i++) begin
      int wp, rp;
      case ((i / 150) % 3)
        0:       begin wp = 75; rp = 35; end
        1:       begin wp = 35; rp = 75; end
        default: begin wp = 60; rp = 60; end
      endcase
      step(($urandom_range(99) < wp), DW'($urandom), ($urandom_range(99) < rp),
           ($urandom_range(79) == 0), ($urandom_range(199) == 0));
    end

    repeat (4) idle();
    @(posedge clk);
    #1;
    check_state();
    chk("reg scoreboard drained", sb0.size(), 0);
    chk("fwft scoreboard drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
